// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the Ethernet receive frame buffer.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_READY   = 3'd3,
    ST_DROP    = 3'd4
  } rx_state_e;

  localparam int          ETH_HDR_BYTES     = 14;
  localparam logic [47:0] ETH_BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_rx_frame_ram.sv
// Simple dual-port payload RAM: synchronous write, combinational (first-word-fall-through) read.
module eth_rx_frame_ram #(
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/eth_rx_frame_buffer.sv
// Single-frame Ethernet receive buffer: parses the 14-byte header, packs payload into 32-bit words.
// Optional destination filter enabled by defining ETH_RX_MAC_FILTER_EN.
module eth_rx_frame_buffer #(
  parameter int          DEPTH_WORDS = 512,
  parameter logic [47:0] MAC_ADDR    = 48'h02_00_00_00_00_01
) (
  input  logic        clk_100_mhz,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_err,
  input  logic        rx_read_en,
  input  logic        rx_clear,
  output logic        rx_ready,
  output logic        rx_empty,
  output logic        rx_overflow,
  output logic [31:0] rx_data,
  output logic [15:0] rx_data_count,
  output logic [31:0] rx_protocol_type
);
  import eth_rx_pkg::*;

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          PW        = AW + 1;
  localparam logic [15:0] MAX_BYTES = 16'(DEPTH_WORDS * 4);

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] HEADER  = ST_HEADER;
  localparam logic [2:0] PAYLOAD = ST_PAYLOAD;
  localparam logic [2:0] READY   = ST_READY;
  localparam logic [2:0] DROP    = ST_DROP;

  logic [2:0]    state;
  logic [3:0]    hdr_cnt;
  logic [15:0]   pay_cnt;
  logic [31:0]   pack;
  logic [15:0]   type_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          held;
  logic          ovf_q;

  logic          start;
  logic [1:0]    lane;
  logic [31:0]   word_n;
  logic          pay_byte;
  logic          ram_we;
  logic          dst_ok;

`ifdef ETH_RX_MAC_FILTER_EN
  logic [39:0] dst_q;
  logic [47:0] dst_full;

  assign dst_full = {dst_q, in_data};
  assign dst_ok   = (dst_full == MAC_ADDR) || (dst_full == ETH_BROADCAST_MAC);

  always_ff @(posedge clk_100_mhz) begin
    if (rst)           dst_q <= '0;
    else if (in_valid) dst_q <= dst_full[39:0];
  end
`else
  logic unused_mac;
  assign unused_mac = ^MAC_ADDR;
  assign dst_ok     = 1'b1;
`endif

  // A new frame may start (or restart) only while no completed frame is held.
  assign start = in_valid && in_sof && (state == IDLE || state == HEADER || state == PAYLOAD);

  always_comb begin
    lane     = pay_cnt[1:0];
    word_n   = (lane == 2'd0) ? {24'd0, in_data}
                              : (pack | ({24'd0, in_data} << {lane, 3'b000}));
    pay_byte = (state == PAYLOAD) && in_valid && !in_sof && !in_err && (pay_cnt != MAX_BYTES);
    ram_we   = pay_byte && ((lane == 2'd3) || in_eof);
  end

  always_ff @(posedge clk_100_mhz) begin
    if (rst) begin
      state            <= IDLE;
      hdr_cnt          <= '0;
      pay_cnt          <= '0;
      pack             <= '0;
      type_q           <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      held             <= 1'b0;
      ovf_q            <= 1'b0;
      rx_data_count    <= '0;
      rx_protocol_type <= '0;
    end else begin
      ovf_q <= 1'b0;
      if (start) begin
        hdr_cnt <= 4'd1;
        pay_cnt <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        if (in_err || in_eof) begin
          ovf_q <= 1'b1;
          state <= in_eof ? IDLE : DROP;
        end else begin
          state <= HEADER;
        end
      end else begin
        case (state)
          IDLE: ;
          HEADER: if (in_valid) begin
            hdr_cnt <= hdr_cnt + 4'd1;
            if (hdr_cnt == 4'(ETH_HDR_BYTES - 2)) type_q[15:8] <= in_data;
            if (hdr_cnt == 4'(ETH_HDR_BYTES - 1)) type_q[7:0]  <= in_data;
            if (in_err || (in_eof && hdr_cnt != 4'(ETH_HDR_BYTES - 1))) begin
              ovf_q <= 1'b1;
              state <= in_eof ? IDLE : DROP;
            end else if (hdr_cnt == 4'd5 && !dst_ok) begin
              state <= in_eof ? IDLE : DROP;
            end else if (in_eof) begin
              state            <= READY;
              held             <= 1'b1;
              rx_data_count    <= '0;
              rx_protocol_type <= {16'd0, type_q[15:8], in_data};
            end else if (hdr_cnt == 4'(ETH_HDR_BYTES - 1)) begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: if (in_valid) begin
            if (!pay_byte) begin
              ovf_q <= 1'b1;
              state <= in_eof ? IDLE : DROP;
            end else begin
              pay_cnt <= pay_cnt + 16'd1;
              pack    <= word_n;
              if (ram_we) wr_ptr <= wr_ptr + PW'(1);
              if (in_eof) begin
                state            <= READY;
                held             <= 1'b1;
                rx_data_count    <= pay_cnt + 16'd1;
                rx_protocol_type <= {16'd0, type_q};
              end
            end
          end
          READY, DROP: begin
            if (rx_clear) begin
              state            <= IDLE;
              held             <= 1'b0;
              wr_ptr           <= '0;
              rd_ptr           <= '0;
              pay_cnt          <= '0;
              hdr_cnt          <= '0;
              rx_data_count    <= '0;
              rx_protocol_type <= '0;
            end else if (state == READY) begin
              if (in_valid && in_sof) begin
                ovf_q <= 1'b1;
                if (!in_eof) state <= DROP;
              end else if (rx_read_en && !rx_empty) begin
                rd_ptr <= rd_ptr + PW'(1);
              end
            end else if (in_valid && in_eof) begin
              state <= held ? READY : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read side: rx_data always shows the word at the read pointer; a word is consumed
  // on a cycle where rx_read_en=1 and rx_empty=0, and the next word appears one cycle later.
  assign rx_ready    = held;
  assign rx_overflow = ovf_q;
  assign rx_empty    = (state != READY) || (rd_ptr == wr_ptr);

  eth_rx_frame_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk_100_mhz),
    .we     (ram_we),
    .wr_addr(wr_ptr[AW-1:0]),
    .wr_data(word_n),
    .rd_addr(rd_ptr[AW-1:0]),
    .rd_data(rx_data)
  );

endmodule

// File: doc/eth_rx_frame_buffer.md
ETH_RX_FRAME_BUFFER -- requirements
Module: eth_rx_frame_buffer

Interface
- REQ-001 SHALL have parameter DEPTH_WORDS, default 512, meaning 32-bit payload words stored (2048 bytes).
- REQ-002 SHALL have parameter MAC_ADDR, default 48'h02_00_00_00_00_01, meaning station address used by the filter.
- REQ-003 SHALL have port clk_100_mhz, input, 1, the single clock, shared with the AXI wrapper.
- REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
- REQ-005 SHALL have port in_data, input, 8, received byte from the RMII deserializer, preamble/SFD already stripped.
- REQ-006 SHALL have ports in_valid, in_sof, in_eof, in_err, each input, 1: byte strobe, first byte, last byte, PHY error; sof/eof/err qualified by in_valid.
- REQ-007 SHALL have ports rx_read_en and rx_clear, each input, 1: pop one word; discard the held frame.
- REQ-008 SHALL have ports rx_ready, rx_empty and rx_overflow, each output, 1: frame held; no unread words; one-cycle pulse on a dropped frame.
- REQ-009 SHALL have port rx_data, output, 32, word at the read pointer (first-word-fall-through).
- REQ-010 SHALL have port rx_data_count, output, 16, payload byte count of the held frame.
- REQ-011 SHALL have port rx_protocol_type, output, 32, EtherType in [15:0] with [31:16] zero.

Function
- REQ-012 SHALL implement states IDLE, HEADER, PAYLOAD, READY and DROP.
- REQ-013 SHALL go IDLE->HEADER on in_valid&in_sof; in_valid without sof in IDLE SHALL be ignored.
- REQ-014 SHALL count header bytes 0..13: bytes 0-5 destination, 6-11 source, 12-13 EtherType (byte 12 -> [15:8]), then go HEADER->PAYLOAD.
- REQ-015 SHALL pack payload little-endian (first byte in [7:0]) and write each full word to RAM.
- REQ-016 SHALL zero-pad a partial final word and write it on in_eof.
- REQ-017 SHALL go PAYLOAD->READY on in_eof; rx_ready SHALL assert the cycle after in_eof is accepted.
- REQ-018 SHALL set rx_data_count to exact payload bytes, so a 14-byte frame gives 0.
- REQ-019 SHALL go to DROP and pulse rx_overflow on: in_err; in_eof before byte 14; payload over DEPTH_WORDS*4 bytes; or in_sof while READY, with the incoming frame discarded and the held frame kept.
- REQ-020 SHALL go DROP->IDLE on the cycle after in_eof, or the same cycle if entered on eof; a held READY frame SHALL remain READY.
- REQ-021 SHALL advance the read pointer on rx_read_en in READY with rx_empty=0, with rx_data valid the next cycle; rx_read_en while empty SHALL be ignored.
- REQ-022 SHALL assert rx_empty when not READY or when read pointer equals words written.
- REQ-023 SHALL act on rx_clear in READY or DROP: clear pointers and counts, go to IDLE next cycle, and deassert rx_ready; rx_clear in HEADER/PAYLOAD SHALL be ignored.
- REQ-024 SHALL give in_sof in HEADER/PAYLOAD priority as a restart: discard partial data, restart HEADER, no overflow pulse.

Reset
- REQ-025 SHALL, on rst, set state to IDLE, all pointers and counters to 0, rx_ready=0, rx_empty=1, rx_overflow=0, rx_data_count=0, rx_protocol_type=0; RAM contents SHALL be don't-care.
- REQ-026 SHALL make rst mid-frame abort the frame silently with no rx_overflow pulse.

Configuration
- REQ-027 SHALL, with macro ETH_RX_MAC_FILTER_EN defined, DROP (without rx_overflow) frames whose destination is neither MAC_ADDR nor FF:FF:FF:FF:FF:FF, decided at byte 5.
- REQ-028 SHALL, without ETH_RX_MAC_FILTER_EN, accept every destination and omit the comparator.

Structure
- REQ-029 SHALL place the state enum, ETH_HDR_BYTES=14 and ETH_BROADCAST_MAC in shared package eth_rx_pkg.
- REQ-030 SHALL instantiate sub-module eth_rx_frame_ram, a simple dual-port RAM of DEPTH_WORDS x 32 with synchronous write and FWFT read path.

Verification
- REQ-031 SHALL cover: 14 header bytes with type 0x0800, then payload 01..06, eof -> rx_ready=1, rx_data_count=6, rx_protocol_type=0x00000800, words 0x04030201 then 0x00000605.
- REQ-032 SHALL cover: in_err on byte 20 -> rx_overflow one pulse, rx_ready stays 0, next good frame accepted.
- REQ-033 SHALL cover: payload 2049 bytes at DEPTH_WORDS=512 -> DROP, rx_overflow pulse, IDLE after eof.
- REQ-034 SHALL cover: second frame sof while READY -> rx_overflow pulse, first frame data and count unchanged; rx_clear -> IDLE, rx_empty=1.
- REQ-035 SHALL cover: with ETH_RX_MAC_FILTER_EN, destination 02:00:00:00:00:02 -> dropped silently; destination FF:FF:FF:FF:FF:FF -> accepted.
- REQ-036 SHALL cover: rst asserted mid-payload -> all outputs at reset values next cycle, no rx_overflow.
